// File: rtl/sram_cfg_pkg.sv
// Shared definitions for the configurable-aspect-ratio SRAM read/write paths:
// extension modes, conf/width relations and the per-request tag.
package sram_cfg_pkg;

    localparam logic [1:0] MODE_REP  = 2'b00;
    localparam logic [1:0] MODE_ZEXT = 2'b01;
    localparam logic [1:0] MODE_SEXT = 2'b10;

    // Tag fields are sized for the widest supported macro; users slice them down.
    localparam int TAG_CONF_W = 5;
    localparam int TAG_ADDR_W = 16;

    typedef struct packed {
        logic [TAG_CONF_W-1:0] conf;
        logic [TAG_ADDR_W-1:0] addr;
        logic [1:0]            mode;
    } tag_t;

    function automatic int conf_width(input int data_w, input int conf);
        return data_w >> conf;
    endfunction

    function automatic int max_legal_conf(input int data_w);
        return $clog2(data_w);
    endfunction

endpackage

// File: rtl/sram_lane_extract.sv
// Combinational lane select plus replicate/zero/sign extension of one narrow word.
// Illegal conf values fall back to full width.
module sram_lane_extract
    import sram_cfg_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int LANE_W = $clog2(DATA_W),
    localparam int CONF_W = $clog2(LANE_W + 1)
) (
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [CONF_W-1:0] i_conf,
    input  logic [LANE_W-1:0] i_addr,
    input  logic [1:0]        i_mode,
    output logic [DATA_W-1:0] o_data
);

    logic [LANE_W:0][DATA_W-1:0] w_cand;
    logic [CONF_W-1:0]           w_conf_eff;

    assign w_cand[0] = i_rdata;

    for (genvar c = 1; c <= max_legal_conf(DATA_W); c++) begin : g_conf
        localparam int W = conf_width(DATA_W, c);

        logic [c-1:0]      w_k;
        logic [LANE_W-1:0] w_off;
        logic [W-1:0]      w_word;

        // Lane k starts at bit k*W; W is a power of two so this is a shift.
        assign w_k    = i_addr[c-1:0];
        assign w_off  = LANE_W'(w_k) << (LANE_W - c);
        assign w_word = i_rdata[w_off +: W];

        assign w_cand[c] = (i_mode == MODE_REP)  ? {(1 << c){w_word}} :
                           (i_mode == MODE_SEXT) ? {{(DATA_W - W){w_word[W-1]}}, w_word} :
                                                   {{(DATA_W - W){1'b0}}, w_word};
    end

    assign w_conf_eff = (i_conf > CONF_W'(LANE_W)) ? '0 : i_conf;
    assign o_data     = w_cand[w_conf_eff];

endmodule

// File: rtl/sram_read_aligner.sv
// Read-data aligner: tracks request tags across the fixed SRAM latency, aligns the
// returned word and queues it in a credit-gated response FIFO.
module sram_read_aligner
    import sram_cfg_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int RD_LAT     = 1,
    parameter  int FIFO_DEPTH = 2,
    localparam int LANE_W     = $clog2(DATA_W),
    localparam int CONF_W     = $clog2(LANE_W + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [CONF_W-1:0] i_req_conf,
    input  logic [LANE_W-1:0] i_req_addr,
    input  logic [1:0]        i_req_mode,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    tag_t              r_tag [RD_LAT];
    logic [RD_LAT-1:0] r_tvld;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_occ;
    logic [CNT_W-1:0]  r_cnt;

    tag_t              w_tag_in;
    tag_t              w_tag_out;
    logic              w_accept;
    logic              w_cap;
    logic              w_pop;
    logic [DATA_W-1:0] w_aligned;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_tag_in      = '0;
        w_tag_in.conf = TAG_CONF_W'(i_req_conf);
        w_tag_in.addr = TAG_ADDR_W'(i_req_addr);
        w_tag_in.mode = i_req_mode;
    end

    // Credits cover both in-flight tags and queued words, so capture never overflows.
    assign o_req_ready = (r_cnt < CNT_W'(FIFO_DEPTH));
    assign o_rsp_valid = (r_occ != '0);
    assign o_rsp_data  = r_mem[r_rptr];

    assign w_accept  = i_req_valid && o_req_ready;
    assign w_pop     = o_rsp_valid && i_rsp_ready;
    assign w_cap     = r_tvld[RD_LAT-1];
    assign w_tag_out = r_tag[RD_LAT-1];

    sram_lane_extract #(
        .DATA_W (DATA_W)
    ) u_extract (
        .i_rdata (i_sram_rdata),
        .i_conf  (w_tag_out.conf[CONF_W-1:0]),
        .i_addr  (w_tag_out.addr[LANE_W-1:0]),
        .i_mode  (w_tag_out.mode),
        .o_data  (w_aligned)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tvld <= '0;
            for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
        end else begin
            r_tvld[0] <= w_accept;
            r_tag[0]  <= w_tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tvld[i] <= r_tvld[i-1];
                r_tag[i]  <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_cap) begin
                r_mem[r_wptr] <= w_aligned;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) r_rptr <= ptr_inc(r_rptr);

            case ({w_cap, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase

            case ({w_accept, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        w_cap |-> ((r_occ < CNT_W'(FIFO_DEPTH)) || w_pop));

endmodule

// File: tb/tb_sram_read_aligner.sv
// Directed bench for sram_read_aligner (32-bit, latency 1, two-entry FIFO) with a
// queue-based scoreboard checked by an independent response monitor.
module tb_sram_read_aligner;

    localparam int DATA_W     = 32;
    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_conf = '0;
    logic [4:0]  req_addr = '0;
    logic [1:0]  req_mode = '0;
    logic [31:0] sram_rdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];

    always #5 clk = ~clk;

    sram_read_aligner #(
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_conf   (req_conf),
        .i_req_addr   (req_addr),
        .i_req_mode   (req_mode),
        .i_sram_rdata (sram_rdata),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: a response handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got 0x%08h expected no response", rsp_data);
            end else begin
                check(name_q.pop_front(), rsp_data, exp_q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the accept edge with read data driven.
    task automatic send(input logic [2:0] c, input logic [4:0] a, input logic [1:0] m,
                        input logic [31:0] rd, input logic [31:0] exp, input string nm);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_conf  = c;
        req_addr  = a;
        req_mode  = m;
        while (!req_ready && n < 50) begin
            cycles(1);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout_%s: got req_ready 0 expected 1 within 50 cycles", nm);
            req_valid = 1'b0;
        end else begin
            cycles(1);
            exp_q.push_back(exp);
            name_q.push_back(nm);
            req_valid  = 1'b0;
            sram_rdata = rd;
        end
    endtask

    initial begin
        int n;
        #12;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_data", rsp_data, 32'h0);
        cycles(1);
        rst_n = 1'b1;
        cycles(1);

        send(3'd0, 5'd0, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, "full_width");
        check("lat_valid_low", rsp_valid, 0);
        cycles(1);
        check("lat_valid_high", rsp_valid, 1);
        cycles(2);

        send(3'd3, 5'd2, 2'b00, 32'h00000A50, 32'hAAAAAAAA, "nib_rep");
        send(3'd3, 5'd2, 2'b01, 32'h00000A50, 32'h0000000A, "nib_zext");
        send(3'd3, 5'd2, 2'b10, 32'h00000A50, 32'hFFFFFFFA, "nib_sext");
        send(3'd5, 5'd31, 2'b10, 32'h80000000, 32'hFFFFFFFF, "bit_sext");
        send(3'd5, 5'd31, 2'b01, 32'h80000000, 32'h00000001, "bit_zext");
        send(3'd5, 5'd30, 2'b01, 32'h80000000, 32'h00000000, "bit_addr30");
        send(3'd5, 5'd31, 2'b11, 32'h80000000, 32'h00000001, "bit_mode11");
        send(3'd1, 5'd1, 2'b10, 32'h80011234, 32'hFFFF8001, "half_sext");
        send(3'd2, 5'd3, 2'b00, 32'h5A000000, 32'h5A5A5A5A, "byte_rep");
        send(3'd4, 5'd5, 2'b10, 32'h00000800, 32'hFFFFFFFE, "pair_sext");
        send(3'd4, 5'd5, 2'b00, 32'h00000800, 32'hAAAAAAAA, "pair_rep");
        send(3'd7, 5'd5, 2'b10, 32'h12345678, 32'h12345678, "illegal_conf");
        cycles(3);
        check("drained_1", rsp_valid, 0);

        rsp_ready = 1'b0;
        send(3'd0, 5'd0, 2'b00, 32'h11111111, 32'h11111111, "bp_a");
        send(3'd0, 5'd0, 2'b01, 32'h22222222, 32'h22222222, "bp_b");
        check("bp_ready_low", req_ready, 0);
        req_valid = 1'b1;
        req_conf  = 3'd3;
        req_addr  = 5'd7;
        req_mode  = 2'b01;
        cycles(3);
        check("bp_c_blocked", req_ready, 0);
        check("bp_head_valid", rsp_valid, 1);
        check("bp_head_stable", rsp_data, 32'h11111111);
        rsp_ready = 1'b1;
        check("bp_ready_before_pop", req_ready, 0);
        cycles(1);
        check("bp_ready_after_pop", req_ready, 1);
        send(3'd3, 5'd7, 2'b01, 32'hB0000000, 32'h0000000B, "bp_c");
        cycles(4);
        check("drained_2", rsp_valid, 0);

        rsp_ready = 1'b0;
        send(3'd0, 5'd0, 2'b00, 32'h33333333, 32'h33333333, "rst_a");
        send(3'd0, 5'd0, 2'b00, 32'h44444444, 32'h44444444, "rst_b");
        cycles(1);
        check("rst_pre_valid", rsp_valid, 1);
        check("rst_pre_ready", req_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", rsp_valid, 0);
        check("rst_async_ready", req_ready, 1);
        check("rst_async_data", rsp_data, 32'h0);
        exp_q.delete();
        name_q.delete();
        #1;
        cycles(2);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sram_rdata = 32'hA5A5A5A5 ^ (32'h01010101 * i);
            cycles(1);
            check("post_rst_no_rsp", rsp_valid, 0);
        end
        check("post_rst_ready", req_ready, 1);

        send(3'd1, 5'd0, 2'b01, 32'hCAFEF00D, 32'h0000F00D, "post_rst_half");
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cycles(1);
            n++;
        end
        check("drain_final", exp_q.size(), 0);
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_read_aligner.md
# sram_read_aligner

Parametrised, flow-controlled read-data aligner for the configurable-aspect-ratio SRAM macro. It tracks each read request's width configuration, lane address and extension mode across the fixed SRAM read latency. It extracts the addressed narrow word from the full-width read data, extends or replicates it to DATA_W, and presents it on a valid/ready response port. A small output FIFO with credit-based request gating absorbs back-pressure, because the SRAM itself cannot stall.

## Interface
Parameters:
- DATA_W, 32: physical SRAM word width; power of two, at least 2.
- RD_LAT, 1: SRAM read latency in cycles from request accept to the sram_rdata sample edge; at least 1.
- FIFO_DEPTH, 2: response FIFO entries; at least 1. This is also the maximum number of outstanding requests.
- Derived: LANE_W = $clog2(DATA_W); CONF_W = $clog2(LANE_W+1).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  read request present.
- req_ready  out  1  request can be accepted.
- req_conf  in  CONF_W  width select: word width W = DATA_W >> req_conf.
- req_addr  in  LANE_W  lane address; only the low req_conf bits are used.
- req_mode  in  2  extension mode: 00 replicate, 01 zero-extend, 10 sign-extend, 11 treated as 01.
- sram_rdata  in  DATA_W  SRAM read data, valid at edge n+RD_LAT for a request accepted at edge n.
- rsp_valid  out  1  aligned response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  aligned, extended response word.

## Operation
- Accept: a request is accepted when req_valid && req_ready at a rising edge. {conf, addr, mode} enter a RD_LAT-deep tag pipeline with a valid bit per stage.
- Illegal conf: conf > LANE_W is treated as conf 0, i.e. full width with addr ignored.
- Lane index: k = addr[conf-1:0]; k = 0 when conf = 0. The selected word is sram_rdata[k*W +: W].
- Replicate mode: the word is repeated DATA_W/W times.
- Zero-extend mode: upper bits are 0.
- Sign-extend mode: upper bits copy bit W-1 of the word.
- Full width: for conf 0 all modes give sram_rdata unchanged.
- Capture: when the last tag stage is valid at an edge, the aligned word is written to the FIFO tail at that edge. sram_rdata is ignored at edges with no valid tag.
- Credits: outstanding count = tags in flight + FIFO occupancy; req_ready = (outstanding < FIFO_DEPTH).
  - Accept alone: count +1.
  - Pop alone (rsp_valid && rsp_ready): count -1.
  - Accept and pop in the same cycle: count unchanged.
  - Because of this gating, a FIFO write always finds a free slot; a FIFO overflow is a design error and is flagged by an assertion.
- Ordering: responses leave strictly in request order.
- rsp_valid = FIFO not empty. rsp_data = FIFO head, registered, with no combinational path from sram_rdata.

## Timing
- Latency: request accepted at edge n → rsp_valid high from just after edge n+RD_LAT (with an empty FIFO).
- Throughput: one request per cycle is sustained when FIFO_DEPTH ≥ RD_LAT+1 and rsp_ready stays high. Otherwise req_ready deasserts periodically.
- req_ready depends only on registered state; it is never a function of req_valid.
- rsp_valid, once high, stays high with rsp_data stable until popped.
- Reset values: all tag valid bits 0, FIFO empty, count 0, rsp_valid 0, rsp_data 0, req_ready 1.
- Reset mid-operation: in-flight tags and queued responses are discarded immediately. sram_rdata returning after reset release for pre-reset requests is ignored.

## Structure
- Shared package sram_cfg_pkg holds:
  - the mode encodings: MODE_REP, MODE_ZEXT, MODE_SEXT;
  - the conf-to-width relation and legal-conf bound as functions of DATA_W;
  - the tag struct {conf, addr, mode}.
- Sub-module sram_lane_extract: purely combinational (DATA_W, conf, addr, mode) → aligned word, reusable by the write path.
- The top level holds the tag pipeline, the credit counter and the FIFO (circular buffer with wrap-around pointers).

## Test plan
All scenarios use DATA_W=32, RD_LAT=1, FIFO_DEPTH=2.
- Full width: conf 0, mode 00, sram_rdata 0xDEADBEEF → rsp_data 0xDEADBEEF, rsp_valid high one cycle after accept.
- Nibble lane: conf 3, addr 2, sram_rdata 0x00000A50. Replicate → 0xAAAAAAAA; zero-extend → 0x0000000A; sign-extend → 0xFFFFFFFA.
- Single bit: conf 5, addr 31, sram_rdata 0x80000000. Sign-extend → 0xFFFFFFFF; zero-extend → 0x00000001. With addr 30 → 0x00000000.
- Back-pressure: rsp_ready 0, three back-to-back requests.
  - Two are accepted; req_ready is low after the second accept.
  - Raising rsp_ready pops them in order.
  - req_ready rises the cycle after the first pop, and the third request is then accepted.
- Illegal conf: conf 7, addr 5, mode 10, sram_rdata 0x12345678 → rsp_data 0x12345678.
- Reset mid-operation: assert rst_n with two responses outstanding.
  - rsp_valid goes 0 and req_ready goes 1 without waiting for a clock.
  - After release, toggling sram_rdata produces no response.
